// File: rtl/fetch_stage.sv
`default_nettype none
// fetch_stage: RV64 instruction fetch with one outstanding bus request and a decode-side output register.
// Optional FETCH_MISALIGN_EN: misaligned fetch PCs skip the bus and present a nop flagged in out_exc.
module fetch_stage #(
    parameter int unsigned     XLEN   = 64,
    parameter logic [XLEN-1:0] PCINIT = XLEN'(64'h0000_0000_8000_0000)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ireq_valid,
    output logic [XLEN-1:0] ireq_addr,
    input  logic            iresp_data_ok,
    input  logic [31:0]     iresp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            dec_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instr,
    output logic            out_exc
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] req_addr_q;
    logic [XLEN-1:0] out_pc_q;
    logic [31:0]     out_instr_q;
    logic            out_valid_q;
    logic [XLEN-1:0] seq_pc_d;

    assign seq_pc_d = out_pc_q + XLEN'(4);

`ifdef FETCH_MISALIGN_EN
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    logic out_exc_q;
    logic misalign_d;

    // Misaligned addresses never reach the bus, so REQ drops its request for them.
    assign misalign_d = (req_addr_q[1:0] != 2'b00);
    assign ireq_valid = ((state_q == ST_REQ) && !misalign_d) || (state_q == ST_DROP);
    assign out_exc    = out_exc_q;
`else
    assign ireq_valid = (state_q == ST_REQ) || (state_q == ST_DROP);
    assign out_exc    = 1'b0;
`endif

    assign ireq_addr = req_addr_q;
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= PCINIT;
            req_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
`ifdef FETCH_MISALIGN_EN
            out_exc_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redirect_valid) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                    end else begin
                        req_addr_q <= pc_q;
                    end
                    state_q <= ST_REQ;
                end

                ST_REQ: begin
`ifdef FETCH_MISALIGN_EN
                    if (misalign_d) begin
                        if (redirect_valid) begin
                            pc_q       <= redirect_pc;
                            req_addr_q <= redirect_pc;
                        end else begin
                            out_valid_q <= 1'b1;
                            out_pc_q    <= req_addr_q;
                            out_instr_q <= NOP_INSTR;
                            out_exc_q   <= 1'b1;
                            state_q     <= ST_HOLD;
                        end
                    end else
`endif
                    if (redirect_valid && iresp_data_ok) begin
                        pc_q       <= redirect_pc;
                        req_addr_q <= redirect_pc;
                    end else if (redirect_valid) begin
                        // Old request stays on the bus until its response is drained in DROP.
                        pc_q    <= redirect_pc;
                        state_q <= ST_DROP;
                    end else if (iresp_data_ok) begin
                        out_valid_q <= 1'b1;
                        out_pc_q    <= req_addr_q;
                        out_instr_q <= iresp_data;
`ifdef FETCH_MISALIGN_EN
                        out_exc_q   <= 1'b0;
`endif
                        state_q     <= ST_HOLD;
                    end
                end

                ST_DROP: begin
                    if (iresp_data_ok) begin
                        req_addr_q <= redirect_valid ? redirect_pc : pc_q;
                        state_q    <= ST_REQ;
                    end
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end
                end

                ST_HOLD: begin
                    if (redirect_valid) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= redirect_pc;
                        req_addr_q  <= redirect_pc;
                        state_q     <= ST_REQ;
                    end else if (dec_ready) begin
                        out_valid_q <= 1'b0;
                        pc_q        <= seq_pc_d;
                        req_addr_q  <= seq_pc_d;
                        state_q     <= ST_REQ;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// tb_fetch_stage: vector table, directed corner sequences and a randomized run against a fetch-stream model.
module tb_fetch_stage;

    localparam int          XLEN   = 64;
    localparam logic [63:0] PCINIT = 64'h0000_0000_8000_0000;

    logic            clk = 1'b0;
    logic            reset;
    logic            ireq_valid;
    logic [XLEN-1:0] ireq_addr;
    logic            iresp_data_ok;
    logic [31:0]     iresp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            dec_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_instr;
    logic            out_exc;

    fetch_stage #(.XLEN(XLEN), .PCINIT(PCINIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .ireq_addr     (ireq_addr),
        .iresp_data_ok (iresp_data_ok),
        .iresp_data    (iresp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_ready     (dec_ready),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_exc       (out_exc)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] data;
        int          resp_wait;
        int          hold_wait;
        logic [63:0] exp_pc;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0000_5A5A;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Starts at a negedge with the DUT requesting v.exp_pc.
    task automatic run_vec(input vec_t v);
        logic [63:0] nxt;
        nxt = v.exp_pc + 64'd4;
        chk("tbl_req_valid", ireq_valid, 1);
        chk("tbl_req_addr", ireq_addr, v.exp_pc);
        for (int k = 0; k < v.resp_wait; k++) begin
            tick();
            chk("tbl_wait_valid", ireq_valid, 1);
            chk("tbl_wait_addr", ireq_addr, v.exp_pc);
            chk("tbl_wait_out_valid", out_valid, 0);
        end
        iresp_data_ok = 1'b1;
        iresp_data    = v.data;
        tick();
        iresp_data_ok = 1'b0;
        iresp_data    = 32'h5555_AAAA;
        chk("tbl_out_valid", out_valid, 1);
        chk("tbl_out_pc", out_pc, v.exp_pc);
        chk("tbl_out_instr", out_instr, v.data);
        chk("tbl_out_exc", out_exc, 0);
        chk("tbl_hold_req", ireq_valid, 0);
        for (int k = 0; k < v.hold_wait; k++) begin
            tick();
            chk("tbl_hold_valid", out_valid, 1);
            chk("tbl_hold_pc", out_pc, v.exp_pc);
            chk("tbl_hold_instr", out_instr, v.data);
            chk("tbl_hold_noreq", ireq_valid, 0);
        end
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("tbl_acc_out_valid", out_valid, 0);
        chk("tbl_acc_req_valid", ireq_valid, 1);
        chk("tbl_acc_req_addr", ireq_addr, nxt);
    endtask

    logic [63:0] m_pc, m_old, m_out_pc;
    logic [31:0] m_out_instr;
    logic        m_held, m_cancel;

    initial begin
        vecs[0] = '{data: 32'h0010_0093, resp_wait: 1, hold_wait: 0, exp_pc: PCINIT};
        vecs[1] = '{data: 32'h0020_0113, resp_wait: 0, hold_wait: 5, exp_pc: PCINIT + 64'd4};
        vecs[2] = '{data: 32'h0030_8193, resp_wait: 0, hold_wait: 0, exp_pc: PCINIT + 64'd8};
        vecs[3] = '{data: 32'hDEAD_BEEF, resp_wait: 4, hold_wait: 2, exp_pc: PCINIT + 64'd12};

        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", ireq_valid, 0);
        chk("rst_req_addr", ireq_addr, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_out_exc", out_exc, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_vec(vecs[i]);
        end

        // Redirect while a request is in flight; response comes 3 cycles later.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0100;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("drop_req_valid", ireq_valid, 1);
            chk("drop_req_addr", ireq_addr, PCINIT + 64'd16);
            chk("drop_out_valid", out_valid, 0);
            if (k < 2) tick();
        end
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hBADB_AD00;
        tick();
        iresp_data_ok = 1'b0;
        chk("drop_discard_valid", out_valid, 0);
        chk("drop_new_req_valid", ireq_valid, 1);
        chk("drop_new_req_addr", ireq_addr, 64'h0000_0000_8000_0100);

        // Redirect and response in the same cycle.
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0200;
        iresp_data_ok  = 1'b1;
        iresp_data     = 32'h1111_2222;
        tick();
        redirect_valid = 1'b0;
        iresp_data_ok  = 1'b0;
        chk("same_out_valid", out_valid, 0);
        chk("same_req_valid", ireq_valid, 1);
        chk("same_req_addr", ireq_addr, 64'h0000_0000_8000_0200);
        tick();
        chk("same_no_pulse", out_valid, 0);

        // Redirect beats dec_ready in HOLD.
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0040_0213;
        tick();
        iresp_data_ok = 1'b0;
        chk("hold_out_pc", out_pc, 64'h0000_0000_8000_0200);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0300;
        dec_ready      = 1'b1;
        tick();
        redirect_valid = 1'b0;
        dec_ready      = 1'b0;
        chk("prio_out_valid", out_valid, 0);
        chk("prio_req_addr", ireq_addr, 64'h0000_0000_8000_0300);

        // PC+4 wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        iresp_data_ok  = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("wrap_req_addr", ireq_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        iresp_data = 32'h0000_0013;
        tick();
        iresp_data_ok = 1'b0;
        chk("wrap_out_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        chk("wrap_req_addr_zero", ireq_addr, 64'd0);

`ifdef FETCH_MISALIGN_EN
        iresp_data_ok = 1'b1;
        iresp_data    = 32'h0000_0073;
        tick();
        iresp_data_ok = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0102;
        tick();
        redirect_valid = 1'b0;
        chk("mis_no_req", ireq_valid, 0);
        tick();
        chk("mis_out_valid", out_valid, 1);
        chk("mis_out_exc", out_exc, 1);
        chk("mis_out_pc", out_pc, 64'h0000_0000_8000_0102);
        chk("mis_out_instr", out_instr, 32'h0000_0013);
        chk("mis_hold_noreq", ireq_valid, 0);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h0000_0000_8000_0400;
        tick();
        redirect_valid = 1'b0;
        chk("mis_exit_req_addr", ireq_addr, 64'h0000_0000_8000_0400);
`endif

        // Asynchronous reset mid-request; a late response in IDLE is ignored.
        #2 reset = 1'b0;
        #1;
        chk("arst_req_valid", ireq_valid, 0);
        chk("arst_req_addr", ireq_addr, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_pc", out_pc, 0);
        @(negedge clk);
        reset         = 1'b1;
        iresp_data_ok = 1'b1;
        iresp_data    = 32'hFFFF_FFFF;
        tick();
        iresp_data_ok = 1'b0;
        chk("late_out_valid", out_valid, 0);
        chk("late_req_valid", ireq_valid, 1);
        chk("late_req_addr", ireq_addr, PCINIT);

        // Randomized run: the model tracks the architectural fetch stream only.
        m_pc     = PCINIT;
        m_old    = '0;
        m_out_pc = '0;
        m_out_instr = '0;
        m_held   = 1'b0;
        m_cancel = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_out_valid", out_valid, m_held);
            chk("rnd_req_valid", ireq_valid, !m_held);
            if (m_held) begin
                chk("rnd_out_pc", out_pc, m_out_pc);
                chk("rnd_out_instr", out_instr, m_out_instr);
                chk("rnd_out_exc", out_exc, 0);
            end else begin
                chk("rnd_req_addr", ireq_addr, m_cancel ? m_old : m_pc);
            end

            redirect_valid = ($urandom_range(7) == 0);
            if ($urandom_range(5) == 0)
                redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0;
            else
                redirect_pc = {$urandom, $urandom} & ~64'd3;
            dec_ready     = $urandom_range(1) == 1;
            iresp_data_ok = ireq_valid && ($urandom_range(2) == 0);
            iresp_data    = mem_word(ireq_addr);

            if (redirect_valid) begin
                if (!m_held && !iresp_data_ok) begin
                    if (!m_cancel) m_old = m_pc;
                    m_cancel = 1'b1;
                end else begin
                    m_cancel = 1'b0;
                end
                m_held = 1'b0;
                m_pc   = redirect_pc;
            end else if (iresp_data_ok) begin
                if (m_cancel) begin
                    m_cancel = 1'b0;
                end else begin
                    m_held      = 1'b1;
                    m_out_pc    = m_pc;
                    m_out_instr = mem_word(m_pc);
                end
            end else if (m_held && dec_ready) begin
                m_held = 1'b0;
                m_pc   = m_out_pc + 64'd4;
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RV64 pipeline; sits directly upstream of the decoder.
- Owns the PC and drives the instruction bus with one outstanding request at a time.
- Holds the returned 32-bit instruction and its PC in an output register until the decode stage accepts it.
- Honours redirects (branch/flush) at any point, including while a bus request is in flight.

Parameters:
- PCINIT, 64'h0000_0000_8000_0000, PC loaded on reset.
- XLEN, 64, PC/address width.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous reset, active-low (0 = in reset)
- ireq_valid  out  1  instruction request valid
- ireq_addr  out  XLEN  request address; held stable while ireq_valid=1 and no data_ok
- iresp_data_ok  in  1  response valid for the outstanding request (one-cycle pulse)
- iresp_data  in  32  instruction word, valid when iresp_data_ok=1
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch PC
- dec_ready  in  1  decode stage accepts the output this cycle
- out_valid  out  1  out_pc/out_instr hold a valid instruction
- out_pc  out  XLEN  PC of out_instr
- out_instr  out  32  raw instruction to decoder
- out_exc  out  1  misaligned-fetch flag (tied 0 unless FETCH_MISALIGN_EN)

Behaviour:
- Registers: state, pc_q (next PC to fetch), req_addr_q (drives ireq_addr), out_valid, out_pc, out_instr, out_exc.
- Reset (reset=0, asynchronous): state=IDLE, pc_q=PCINIT, req_addr_q=0. ireq_valid=0, out_valid=0, out_pc=0, out_instr=0, out_exc=0.
- ireq_valid = (state==REQ || state==DROP); it is a registered-state decode with no combinational path from inputs.
- IDLE: on the first clock after reset release, req_addr_q<=pc_q and go to REQ.
- REQ, in priority order:
  - redirect_valid && iresp_data_ok: discard the data; pc_q<=redirect_pc; req_addr_q<=redirect_pc; stay in REQ.
  - redirect_valid only: pc_q<=redirect_pc; go to DROP. req_addr_q is unchanged, so the address stays stable until the old response arrives.
  - iresp_data_ok only: out_instr<=iresp_data; out_pc<=req_addr_q; out_valid<=1; go to HOLD.
- DROP: on iresp_data_ok, discard the data, req_addr_q<=pc_q, go to REQ. A redirect in DROP only updates pc_q.
- HOLD: out_* are stable, ireq_valid=0.
  - redirect_valid (priority over dec_ready): out_valid<=0; pc_q<=redirect_pc; req_addr_q<=redirect_pc; go to REQ.
  - else if dec_ready: out_valid<=0; pc_q<=out_pc+4; req_addr_q<=out_pc+4; go to REQ.
- Timing: if the bus returns data_ok in the first REQ cycle, a new instruction appears every 2 cycles. out_valid rises the cycle after data_ok.
- Wrap-around: PC+4 is modulo 2^XLEN, with no trap.
- A redirect never lets a stale response reach out_*. There is never more than one outstanding request.
- Reset mid-request: all state clears immediately. Any late data_ok arriving in IDLE is ignored.
- Response spacing: data_ok may arrive in the same cycle the request is first asserted (zero-wait bus) or any number of cycles later.

Optional Feature:
- FETCH_MISALIGN_EN
- Defined, when entering REQ with req_addr_q[1:0]!=0:
  - No bus request is made; ireq_valid stays 0 in that cycle.
  - Next cycle: out_valid=1, out_exc=1, out_instr=32'h0000_0013 (nop), out_pc=misaligned address; go to HOLD.
  - HOLD and redirect rules apply unchanged.
- Undefined: no alignment check; out_exc is constant 0; misaligned addresses go to the bus as-is.

Test Plan:
- Reset release, bus responds 1 cycle after request with 32'h00100093 -> ireq_addr=0x80000000; out_valid=1, out_pc=0x80000000, out_instr=0x00100093; after dec_ready, next ireq_addr=0x80000004.
- dec_ready held 0 for 5 cycles in HOLD -> out_* stable, ireq_valid=0 throughout; accept on cycle 6 -> REQ at out_pc+4.
- Redirect to 0x80000100 while waiting, response 3 cycles later -> ireq_addr stays 0x80000000 until data_ok; data discarded (out_valid stays 0); next request at 0x80000100.
- redirect_valid and iresp_data_ok in the same cycle -> data dropped; ireq_addr=redirect_pc next cycle; no out_valid pulse.
- redirect_valid and dec_ready both high in HOLD -> redirect wins; next ireq_addr=redirect_pc, not out_pc+4.
- FETCH_MISALIGN_EN defined, redirect to 0x80000102 -> no ireq_valid for that address; out_valid=1, out_exc=1, out_pc=0x80000102, out_instr=0x00000013.
